// File: rtl/jump_ctl_if.sv
// Player/game-logic bus between the stimulus side and the jump controller.
interface jump_ctl_if #(
  parameter int unsigned SCORE_WIDTH = 14
);
  logic                   module_en;
  logic                   one_ms_tick;
  logic                   btn_left;
  logic                   btn_right;
  logic                   landed;
  logic                   jump_left;
  logic                   jump_right;
  logic                   jump_fail;
  logic                   next_side;
  logic [SCORE_WIDTH-1:0] score;
  logic                   game_over;

  // Side that drives keys, ticks and the landed pulse.
  modport master (
    output module_en, one_ms_tick, btn_left, btn_right, landed,
    input  jump_left, jump_right, jump_fail, next_side, score, game_over
  );

  // The jump controller itself.
  modport slave (
    input  module_en, one_ms_tick, btn_left, btn_right, landed,
    output jump_left, jump_right, jump_fail, next_side, score, game_over
  );
endinterface

// File: rtl/jump_ctl.sv
// Jump controller: key presses -> jump commands, reaction deadline, score and game-over.
module jump_ctl #(
  parameter int unsigned REACTION_MS = 1000,
  parameter int unsigned SCORE_WIDTH = 14,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input logic       clk,
  input logic       rst,
  jump_ctl_if.slave bus
);

  localparam int unsigned TIMER_W = (REACTION_MS > 1) ? $clog2(REACTION_MS) : 1;
  localparam logic [TIMER_W-1:0]     TIMER_LAST = TIMER_W'(REACTION_MS - 1);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX  = '1;

  typedef enum logic [1:0] {S_READY, S_JUMP, S_FALL, S_OVER} state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_LEFT, CMD_RIGHT, CMD_FAIL} cmd_t;

  state_t                 state_q, state_d;
  cmd_t                   cmd_c;
  logic [7:0]             lfsr_q, lfsr_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic                   btn_left_q, btn_right_q;
  logic                   jump_left_q, jump_right_q, jump_fail_q, game_over_q;
  logic                   jump_left_d, jump_right_d, jump_fail_d, game_over_d;

  logic press_left_c, press_right_c, match_c, deadline_c, land_ok_c;

  // Rising-edge detection and decision terms.
  assign press_left_c  = bus.btn_left  & ~btn_left_q;
  assign press_right_c = bus.btn_right & ~btn_right_q;
  assign match_c       = lfsr_q[0] ? press_right_c : press_left_c;
  assign deadline_c    = bus.one_ms_tick && (timer_q == TIMER_LAST);
  assign land_ok_c     = (state_q == S_JUMP) && bus.landed;

  // State register plus all datapath registers; module_en low mirrors reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_READY;
      lfsr_q       <= LFSR_SEED;
      timer_q      <= '0;
      score_q      <= '0;
      btn_left_q   <= bus.btn_left;
      btn_right_q  <= bus.btn_right;
      jump_left_q  <= 1'b0;
      jump_right_q <= 1'b0;
      jump_fail_q  <= 1'b0;
      game_over_q  <= 1'b0;
    end else if (!bus.module_en) begin
      state_q      <= S_READY;
      lfsr_q       <= LFSR_SEED;
      timer_q      <= '0;
      score_q      <= '0;
      btn_left_q   <= bus.btn_left;
      btn_right_q  <= bus.btn_right;
      jump_left_q  <= 1'b0;
      jump_right_q <= 1'b0;
      jump_fail_q  <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      timer_q      <= timer_d;
      score_q      <= score_d;
      btn_left_q   <= bus.btn_left;
      btn_right_q  <= bus.btn_right;
      jump_left_q  <= jump_left_d;
      jump_right_q <= jump_right_d;
      jump_fail_q  <= jump_fail_d;
      game_over_q  <= game_over_d;
    end
  end

  // Next-state and command decision; READY priority: both, match, mismatch, deadline.
  always_comb begin
    state_d = state_q;
    cmd_c   = CMD_NONE;
    case (state_q)
      S_READY: begin
        if (press_left_c && press_right_c) begin
          cmd_c   = CMD_FAIL;
          state_d = S_FALL;
        end else if (match_c) begin
          cmd_c   = lfsr_q[0] ? CMD_RIGHT : CMD_LEFT;
          state_d = S_JUMP;
        end else if (press_left_c || press_right_c) begin
          cmd_c   = CMD_FAIL;
          state_d = S_FALL;
        end else if (deadline_c) begin
          cmd_c   = CMD_FAIL;
          state_d = S_FALL;
        end
      end
      S_JUMP:  if (bus.landed) state_d = S_READY;
      S_FALL:  if (bus.landed) state_d = S_OVER;
      S_OVER:  state_d = S_OVER;
      default: state_d = S_READY;
    endcase
  end

  // Next values for the registered outputs, timer, score and LFSR.
  always_comb begin
    jump_left_d  = 1'b0;
    jump_right_d = 1'b0;
    jump_fail_d  = 1'b0;
    game_over_d  = 1'b0;
    timer_d      = '0;
    score_d      = score_q;
    lfsr_d       = lfsr_q;

    jump_left_d  = (cmd_c == CMD_LEFT);
    jump_right_d = (cmd_c == CMD_RIGHT);
    jump_fail_d  = (cmd_c == CMD_FAIL);
    game_over_d  = (state_d == S_OVER);

    // Deadline tick always leaves READY, so the timer cannot exceed TIMER_LAST.
    if ((state_q == S_READY) && (state_d == S_READY)) begin
      timer_d = bus.one_ms_tick ? (timer_q + TIMER_W'(1)) : timer_q;
    end

    if (land_ok_c) begin
      score_d = (score_q == SCORE_MAX) ? score_q : (score_q + SCORE_WIDTH'(1));
      lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign bus.jump_left  = jump_left_q;
  assign bus.jump_right = jump_right_q;
  assign bus.jump_fail  = jump_fail_q;
  assign bus.next_side  = lfsr_q[0];
  assign bus.score      = score_q;
  assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_jump_ctl.sv
// Directed bench for jump_ctl with a game-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_jump_ctl;

  localparam int unsigned REACTION_MS = 1000;
  localparam int unsigned SCORE_WIDTH = 14;
  localparam int unsigned SCORE_MAX   = (1 << SCORE_WIDTH) - 1;

  localparam int PH_READY = 0;
  localparam int PH_JUMP  = 1;
  localparam int PH_FALL  = 2;
  localparam int PH_OVER  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  jump_ctl_if #(.SCORE_WIDTH(SCORE_WIDTH)) bif ();

  jump_ctl #(
    .REACTION_MS (REACTION_MS),
    .SCORE_WIDTH (SCORE_WIDTH),
    .LFSR_SEED   (8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  // Reference model state (game-level view).
  int         m_phase  = PH_READY;
  int         m_ticks  = 0;
  int         m_score  = 0;
  logic [7:0] m_lfsr   = 8'hA5;
  logic       m_prev_l = 1'b0;
  logic       m_prev_r = 1'b0;
  logic       e_left   = 1'b0;
  logic       e_right  = 1'b0;
  logic       e_fail   = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Taps 7,5,4,3 expressed as parity of a mask.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & 8'b1011_1000)};
  endfunction

  function automatic void m_reset();
    m_phase  = PH_READY;
    m_ticks  = 0;
    m_score  = 0;
    m_lfsr   = 8'hA5;
    m_prev_l = bif.btn_left;
    m_prev_r = bif.btn_right;
    e_left   = 1'b0;
    e_right  = 1'b0;
    e_fail   = 1'b0;
  endfunction

  function automatic void m_fail();
    e_fail  = 1'b1;
    m_phase = PH_FALL;
    m_ticks = 0;
  endfunction

  function automatic void m_step();
    logic pl, pr, want_r;
    pl       = bif.btn_left  & ~m_prev_l;
    pr       = bif.btn_right & ~m_prev_r;
    m_prev_l = bif.btn_left;
    m_prev_r = bif.btn_right;
    e_left   = 1'b0;
    e_right  = 1'b0;
    e_fail   = 1'b0;
    want_r   = m_lfsr[0];
    case (m_phase)
      PH_READY: begin
        if (pl && pr) m_fail();
        else if (want_r ? pr : pl) begin
          e_right = want_r;
          e_left  = ~want_r;
          m_phase = PH_JUMP;
          m_ticks = 0;
        end else if (pl || pr) m_fail();
        else if (bif.one_ms_tick) begin
          m_ticks++;
          if (m_ticks >= int'(REACTION_MS)) m_fail();
        end
      end
      PH_JUMP: if (bif.landed) begin
        m_score = (m_score == int'(SCORE_MAX)) ? m_score : m_score + 1;
        m_lfsr  = lfsr_next(m_lfsr);
        m_phase = PH_READY;
      end
      PH_FALL: if (bif.landed) m_phase = PH_OVER;
      default: ;
    endcase
  endfunction

  // Model update on every edge that can change the DUT, then compare shortly after.
  always @(posedge clk or negedge rst) begin
    if (!rst || !bif.module_en) m_reset();
    else m_step();
    #1;
    chk("jump_left",  32'(bif.jump_left),  32'(e_left));
    chk("jump_right", 32'(bif.jump_right), 32'(e_right));
    chk("jump_fail",  32'(bif.jump_fail),  32'(e_fail));
    chk("next_side",  32'(bif.next_side),  32'(m_lfsr[0]));
    chk("score",      32'(bif.score),      32'(m_score));
    chk("game_over",  32'(bif.game_over),  32'(m_phase == PH_OVER));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic land();
    bif.landed = 1'b1;
    cyc(1);
    bif.landed = 1'b0;
  endtask

  task automatic clear();
    bif.module_en = 1'b0;
    cyc(1);
    bif.module_en = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bif.one_ms_tick = 1'b1;
      cyc(1);
      bif.one_ms_tick = 1'b0;
      cyc(1);
    end
  endtask

  // Watchdog: the run is fixed-length, so this only fires on a broken clock/sim.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bif.module_en   = 1'b1;
    bif.one_ms_tick = 1'b0;
    bif.btn_left    = 1'b0;
    bif.btn_right   = 1'b0;
    bif.landed      = 1'b0;
    #2 rst = 1'b0;
    cyc(2);
    chk("rst_next_side", 32'(bif.next_side), 32'd1);
    chk("rst_score",     32'(bif.score),     32'd0);
    chk("rst_game_over", 32'(bif.game_over), 32'd0);
    rst = 1'b1;
    cyc(1);

    // Correct right jump, single-cycle pulse, landing advances LFSR A5 -> 4A.
    bif.btn_right = 1'b1;
    cyc(1);
    chk("t1_jump_right", 32'(bif.jump_right), 32'd1);
    bif.btn_right = 1'b0;
    cyc(1);
    chk("t1_pulse_1cyc", 32'(bif.jump_right), 32'd0);
    land();
    chk("t1_score",     32'(bif.score),     32'd1);
    chk("t1_next_side", 32'(bif.next_side), 32'd0);
    chk("t1_lfsr",      32'(dut.lfsr_q),    32'h4A);

    // Held key through landing does not retrigger (side becomes 1 after 4A -> 95).
    bif.btn_left = 1'b1;
    cyc(1);
    chk("t4_jump_left", 32'(bif.jump_left), 32'd1);
    land();
    chk("t4_side_95", 32'(bif.next_side), 32'd1);
    cyc(3);
    chk("t4_held_no_fail", 32'(bif.jump_fail), 32'd0);
    bif.btn_left = 1'b0;
    cyc(1);
    bif.btn_right = 1'b1;
    cyc(1);
    chk("t4_repress", 32'(bif.jump_right), 32'd1);
    bif.btn_right = 1'b0;
    land();
    chk("t4_score3", 32'(bif.score), 32'd3);

    // Both keys rising together fails; fall ends in game over.
    bif.btn_left  = 1'b1;
    bif.btn_right = 1'b1;
    cyc(1);
    chk("t4_both_fail", 32'(bif.jump_fail), 32'd1);
    chk("t4_both_nojmp", 32'(bif.jump_left | bif.jump_right), 32'd0);
    bif.btn_left  = 1'b0;
    bif.btn_right = 1'b0;
    cyc(1);
    bif.btn_right = 1'b1;
    cyc(1);
    bif.btn_right = 1'b0;
    land();
    chk("t4_over", 32'(bif.game_over), 32'd1);
    bif.btn_left = 1'b1;
    land();
    bif.btn_left = 1'b0;
    cyc(2);
    chk("over_score_hold", 32'(bif.score), 32'd3);

    // Wrong side from a fresh start (side=1, left pressed).
    clear();
    chk("en_clr_over",  32'(bif.game_over), 32'd0);
    chk("en_clr_score", 32'(bif.score),     32'd0);
    chk("en_clr_lfsr",  32'(dut.lfsr_q),    32'hA5);
    bif.btn_left = 1'b1;
    cyc(1);
    chk("t2_wrong_fail", 32'(bif.jump_fail), 32'd1);
    bif.btn_left = 1'b0;
    land();
    chk("t2_over", 32'(bif.game_over), 32'd1);
    bif.btn_right = 1'b1;
    cyc(1);
    bif.btn_right = 1'b0;
    land();
    chk("t2_over_stays", 32'(bif.game_over), 32'd1);
    chk("t2_over_jr",    32'(bif.jump_right), 32'd0);

    // Reaction deadline: fail only after the 1000th tick.
    clear();
    ticks(999);
    chk("t3_no_early", 32'(bif.jump_fail), 32'd0);
    bif.one_ms_tick = 1'b1;
    cyc(1);
    bif.one_ms_tick = 1'b0;
    chk("t3_deadline", 32'(bif.jump_fail), 32'd1);
    cyc(1);

    // Press in the same cycle as the deadline tick wins.
    clear();
    ticks(999);
    bif.one_ms_tick = 1'b1;
    bif.btn_right   = 1'b1;
    cyc(1);
    bif.one_ms_tick = 1'b0;
    bif.btn_right   = 1'b0;
    chk("dl_press_wins", 32'(bif.jump_right), 32'd1);
    chk("dl_press_nofail", 32'(bif.jump_fail), 32'd0);
    land();
    land();
    chk("ready_land_ign", 32'(bif.score), 32'd1);

    // Score saturation: 2^14-1 successful jumps, then one more.
    clear();
    for (int i = 0; i < int'(SCORE_MAX); i++) begin
      if (m_lfsr[0]) bif.btn_right = 1'b1;
      else bif.btn_left = 1'b1;
      cyc(1);
      bif.btn_left  = 1'b0;
      bif.btn_right = 1'b0;
      land();
    end
    chk("t5_score_max", 32'(bif.score), 32'(SCORE_MAX));
    if (m_lfsr[0]) bif.btn_right = 1'b1;
    else bif.btn_left = 1'b1;
    cyc(1);
    bif.btn_left  = 1'b0;
    bif.btn_right = 1'b0;
    chk("t5_jump_issued", 32'(bif.jump_left | bif.jump_right), 32'd1);
    land();
    chk("t5_score_sat", 32'(bif.score), 32'(SCORE_MAX));

    // Async reset mid-jump clears outputs without a clock edge.
    if (m_lfsr[0]) bif.btn_right = 1'b1;
    else bif.btn_left = 1'b1;
    cyc(1);
    bif.btn_left  = 1'b0;
    bif.btn_right = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("t6_async_score", 32'(bif.score), 32'd0);
    chk("t6_async_jump",  32'(bif.jump_left | bif.jump_right), 32'd0);
    chk("t6_async_side",  32'(bif.next_side), 32'd1);
    cyc(1);
    rst = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jump_ctl.md
Name: jump_ctl

Overview:
- Game-logic stage directly upstream of the character sprite block.
- Turns player key presses into single-cycle jump_left / jump_right / jump_fail commands and tracks the side of the next platform with an LFSR.
- Enforces a per-jump reaction deadline and consumes the character's landed pulse.
- Keeps the score and raises game_over after a failed jump finishes falling.

Parameters:
- REACTION_MS, 1000: ms allowed between becoming ready and a key press before an automatic fail.
- SCORE_WIDTH, 14: score counter width.
- LFSR_SEED, 8'hA5: LFSR value loaded on reset or when disabled; must be non-zero.

Ports:
- clk  in  1  pixel/system clock.
- rst  in  1  asynchronous, active-low reset.
- module_en  in  1  block enable; 0 acts as a synchronous clear to the reset state.
- one_ms_tick  in  1  one-cycle pulse every 1 ms.
- btn_left  in  1  level, synchronised key state.
- btn_right  in  1  level, synchronised key state.
- landed  in  1  one-cycle pulse from the character block when its motion completes.
- jump_left  out  1  one-cycle command pulse.
- jump_right  out  1  one-cycle command pulse.
- jump_fail  out  1  one-cycle command pulse.
- next_side  out  1  side of the next platform, equal to lfsr[0]; 1 = right, 0 = left.
- score  out  SCORE_WIDTH  successful landings, saturating.
- game_over  out  1  level; high in S_OVER.

Behaviour:
- Reset (rst=0, async) and module_en=0 (sync) load the same state:
  - state=S_READY, lfsr=LFSR_SEED, timer=0, score=0.
  - All pulse outputs 0, game_over=0.
  - Edge registers loaded with the current button levels.
- All outputs are registered; each command pulse appears one cycle after the decisive input edge.
- Edge detection:
  - press_x = btn_x & ~btn_x_q.
  - btn_x_q updates every enabled cycle in every state, so a key held when entering S_READY does not trigger.
- LFSR:
  - 8-bit, update lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Advances only on a successful landing.
- States:
  - S_READY:
    - Timer counts one_ms_tick.
    - Priority, first match wins:
      1. Both presses in the same cycle -> jump_fail, go to S_FALL.
      2. The press matching next_side -> jump_right or jump_left, go to S_JUMP.
      3. The non-matching press -> jump_fail, go to S_FALL.
      4. one_ms_tick with timer==REACTION_MS-1 -> jump_fail, go to S_FALL.
    - Timer clears on leaving S_READY.
    - A press in the same cycle as the deadline tick wins over the deadline.
  - S_JUMP:
    - Presses are ignored.
    - landed -> score+1 (held at all-ones once saturated), advance the LFSR, go to S_READY.
  - S_FALL:
    - Presses are ignored.
    - landed -> go to S_OVER; score unchanged.
  - S_OVER:
    - game_over=1.
    - All inputs ignored until module_en=0 or rst=0.
- landed arriving in S_READY or S_OVER is ignored.
- Exactly one of jump_left, jump_right, jump_fail may be high in any cycle.
- Timer width is $clog2(REACTION_MS); the counter never wraps.

Test Plan:
1. Reset with seed A5 -> next_side=1. Pulse btn_right -> jump_right high for exactly 1 cycle. Then landed -> score=1, lfsr=8'h4A, next_side=0, back in S_READY.
2. From S_READY with next_side=1, press btn_left -> jump_fail pulse. Then landed -> game_over=1. Further presses and landed pulses -> no output change, score unchanged.
3. No press for 1000 one_ms_tick pulses -> jump_fail issued on the cycle after the 1000th tick, not earlier.
4. btn_right held through landed -> no new jump until the key is released and pressed again. btn_left and btn_right rising in the same cycle -> jump_fail.
5. Force score to all-ones (2^14-1), then a successful jump and landed -> score stays at 2^14-1.
6. Assert rst=0 mid-jump without a clock edge -> outputs clear immediately. module_en=0 for 1 cycle in S_OVER -> game_over=0, score=0, lfsr=A5.
